// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the CPU data-write strobe and the uart_tx serialiser.
// Bytes are queued in a circular buffer and handed to uart_tx one at a time.
module uart_tx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  cpu_clk,
    input  logic                  rstn,
    input  logic                  wr_en_i,
    input  logic [7:0]            wr_data_i,
    input  logic                  clr_overflow_i,
    input  logic                  uart_tx_busy_i,
    output logic                  uart_tx_en_o,
    output logic [7:0]            uart_tx_data_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic                  idle_o
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LevelFull = Depth[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   LevelOne  = 1;
    localparam logic [DEPTH_LOG2-1:0] PtrOne    = 1;

    typedef enum logic [1:0] {StIdle, StLaunch, StGuard, StDrain} state_e;

    state_e                state_q;
    logic [7:0]            mem_q [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q;
    logic [DEPTH_LOG2:0]   level_d;
    logic                  overflow_q;
    logic                  uart_tx_en_q;
    logic [7:0]            uart_tx_data_q;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LevelFull);

    // A pop frees a slot in the same cycle, so a write at full still fits.
    assign pop  = (state_q == StIdle) && !empty && !uart_tx_busy_i;
    assign push = wr_en_i && (!full || pop);
    assign drop = wr_en_i && full && !pop;

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LevelOne;
        end else if (pop && !push) begin
            level_d = level_q - LevelOne;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!rstn) begin
            state_q        <= StIdle;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            overflow_q     <= 1'b0;
            uart_tx_en_q   <= 1'b0;
            uart_tx_data_q <= 8'h00;
        end else begin
            level_q      <= level_d;
            uart_tx_en_q <= 1'b0;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow_i) begin
                overflow_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_q        <= StLaunch;
                        uart_tx_en_q   <= 1'b1;
                        uart_tx_data_q <= mem_q[rd_ptr_q];
                        rd_ptr_q       <= rd_ptr_q + PtrOne;
                    end
                end
                StLaunch: state_q <= StGuard;
                // uart_tx only raises busy one cycle after it samples en.
                StGuard:  state_q <= StDrain;
                StDrain: begin
                    if (!uart_tx_busy_i) begin
                        state_q <= StIdle;
                    end
                end
                default:  state_q <= StIdle;
            endcase
        end
    end

    assign uart_tx_en_o   = uart_tx_en_q;
    assign uart_tx_data_o = uart_tx_data_q;
    assign level_o        = level_q;
    assign empty_o        = empty;
    assign full_o         = full;
    assign overflow_o     = overflow_q;
    assign idle_o         = empty && (state_q == StIdle) && !uart_tx_busy_i;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural uart_tx busy model.
module tb_uart_tx_fifo;

    localparam int unsigned DW    = 4;
    localparam int unsigned DEPTH = 1 << DW;

    logic          cpu_clk = 1'b0;
    logic          rstn = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          clr_overflow = 1'b0;
    logic          uart_tx_busy;
    logic          uart_tx_en;
    logic [7:0]    uart_tx_data;
    logic [DW:0]   level;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          idle;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q [$];

    int busy_len = 6;
    int busy_cnt = 0;
    bit hold_busy = 1'b0;

    int cycle = 0;
    int last_fall = -1000;
    int en_count = 0;
    logic busy_prev = 1'b0;
    logic en_prev = 1'b0;

    uart_tx_fifo #(.DEPTH_LOG2(DW)) dut (
        .cpu_clk        (cpu_clk),
        .rstn           (rstn),
        .wr_en_i        (wr_en),
        .wr_data_i      (wr_data),
        .clr_overflow_i (clr_overflow),
        .uart_tx_busy_i (uart_tx_busy),
        .uart_tx_en_o   (uart_tx_en),
        .uart_tx_data_o (uart_tx_data),
        .level_o        (level),
        .empty_o        (empty),
        .full_o         (full),
        .overflow_o     (overflow),
        .idle_o         (idle)
    );

    always #5 cpu_clk = ~cpu_clk;

    // uart_tx model: busy rises the cycle after en is sampled.
    always @(posedge cpu_clk) begin
        if (!rstn) busy_cnt <= 0;
        else if (uart_tx_en) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign uart_tx_busy = (busy_cnt != 0) || hold_busy;

    always @(negedge cpu_clk) begin
        cycle++;
        if (!rstn) begin
            en_prev = 1'b0;
            busy_prev = 1'b0;
        end else begin
            if (busy_prev && !uart_tx_busy) last_fall = cycle;
            checks++;
            if (level > DEPTH) begin
                failures++;
                $display("FAIL level_bound: level=%0d, required <= %0d", level, DEPTH);
            end
            if (uart_tx_en) begin
                en_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_en: data=%h, required no en (nothing queued)",
                             uart_tx_data);
                end else begin
                    logic [7:0] exp;
                    exp = exp_q.pop_front();
                    if (uart_tx_data !== exp) begin
                        failures++;
                        $display("FAIL tx_data: got %h, required %h", uart_tx_data, exp);
                    end
                end
                checks++;
                if (en_prev) begin
                    failures++;
                    $display("FAIL en_width: en high two cycles in a row, required one-cycle pulse");
                end
                checks++;
                if (cycle - last_fall < 2) begin
                    failures++;
                    $display("FAIL en_gap: en %0d cycles after busy fell, required >= 2",
                             cycle - last_fall);
                end
            end
            en_prev = uart_tx_en;
            busy_prev = uart_tx_busy;
        end
    end

    // Holds the write for one cycle; caller is just past a posedge.
    task automatic write_byte(input logic [7:0] d, input bit accept);
        wr_en = 1'b1;
        wr_data = d;
        if (accept) exp_q.push_back(d);
        @(posedge cpu_clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge cpu_clk);
            if (idle && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_drain: idle=%b pending=%0d, required idle with none pending",
                     name, idle, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge cpu_clk);
            #1;
            wr_en = ~wr_en;
            wr_data = 8'hC0 + 8'(i);
        end
        @(posedge cpu_clk);
        #1;
        wr_en = 1'b0;
        rstn = 1'b1;
        @(negedge cpu_clk);
        checks++;
        if (level !== '0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: level=%0d empty=%b full=%b ovf=%b, required 0 1 0 0",
                     level, empty, full, overflow);
        end
        checks++;
        if (uart_tx_en !== 1'b0 || uart_tx_data !== 8'h00 || idle !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx: en=%b data=%h idle=%b, required 0 00 1",
                     uart_tx_en, uart_tx_data, idle);
        end
    endtask

    task automatic test_single();
        bit fell = 1'b0;
        busy_len = 128;
        @(posedge cpu_clk);
        #1;
        wr_en = 1'b1;
        wr_data = 8'h41;
        exp_q.push_back(8'h41);
        @(negedge cpu_clk);
        checks++;
        if (uart_tx_en !== 1'b0) begin
            failures++;
            $display("FAIL single_n0: en=%b, required 0", uart_tx_en);
        end
        @(posedge cpu_clk);
        #1;
        wr_en = 1'b0;
        @(negedge cpu_clk);
        checks++;
        if (uart_tx_en !== 1'b0 || level !== 1) begin
            failures++;
            $display("FAIL single_n1: en=%b level=%0d, required 0 1", uart_tx_en, level);
        end
        @(negedge cpu_clk);
        checks++;
        if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'h41 || level !== 0) begin
            failures++;
            $display("FAIL single_n2: en=%b data=%h level=%0d, required 1 41 0",
                     uart_tx_en, uart_tx_data, level);
        end
        @(negedge cpu_clk);
        for (int i = 0; i < 200; i++) begin
            if (!uart_tx_busy) begin
                fell = 1'b1;
                break;
            end
            checks++;
            if (idle !== 1'b0) begin
                failures++;
                $display("FAIL single_busy_idle: idle=%b while busy, required 0", idle);
            end
            @(negedge cpu_clk);
        end
        checks++;
        if (!fell || idle !== 1'b0) begin
            failures++;
            $display("FAIL single_drain: fell=%b idle=%b, required 1 0", fell, idle);
        end
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        checks++;
        if (idle !== 1'b1 || uart_tx_data !== 8'h41) begin
            failures++;
            $display("FAIL single_idle: idle=%b data=%h, required 1 41", idle, uart_tx_data);
        end
    endtask

    task automatic test_burst();
        int start = en_count;
        busy_len = 6;
        @(posedge cpu_clk);
        #1;
        for (int i = 1; i <= 5; i++) write_byte(8'(i), 1'b1);
        wait_idle(300, "burst");
        checks++;
        if (en_count - start != 5) begin
            failures++;
            $display("FAIL burst_count: %0d en pulses, required 5", en_count - start);
        end
    endtask

    task automatic test_full_overflow();
        busy_len = 6;
        @(posedge cpu_clk);
        #1;
        write_byte(8'h10, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge cpu_clk);
            if (uart_tx_en) break;
        end
        @(posedge cpu_clk);
        #1;
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i), 1'b1);
        @(negedge cpu_clk);
        checks++;
        if (level !== 16 || full !== 1'b1 || empty !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_level: level=%0d full=%b empty=%b ovf=%b, required 16 1 0 0",
                     level, full, empty, overflow);
        end
        @(posedge cpu_clk);
        #1;
        write_byte(8'h99, 1'b0);
        @(negedge cpu_clk);
        checks++;
        if (overflow !== 1'b1 || level !== 16) begin
            failures++;
            $display("FAIL ovf_set: ovf=%b level=%0d, required 1 16", overflow, level);
        end
        @(posedge cpu_clk);
        #1;
        clr_overflow = 1'b1;
        @(posedge cpu_clk);
        #1;
        clr_overflow = 1'b0;
        @(negedge cpu_clk);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: ovf=%b, required 0", overflow);
        end
        @(posedge cpu_clk);
        #1;
        clr_overflow = 1'b1;
        write_byte(8'h98, 1'b0);
        clr_overflow = 1'b0;
        @(negedge cpu_clk);
        checks++;
        if (overflow !== 1'b1 || level !== 16) begin
            failures++;
            $display("FAIL ovf_priority: ovf=%b level=%0d, required 1 16", overflow, level);
        end
        @(posedge cpu_clk);
        #1;
        clr_overflow = 1'b1;
        @(posedge cpu_clk);
        #1;
        clr_overflow = 1'b0;
    endtask

    task automatic test_write_pop_full();
        busy_len = 4;
        @(posedge cpu_clk);
        #1;
        hold_busy = 1'b0;
        @(posedge cpu_clk);
        #1;
        write_byte(8'hAA, 1'b1);
        @(negedge cpu_clk);
        checks++;
        if (level !== 16 || full !== 1'b1 || overflow !== 1'b0 || uart_tx_en !== 1'b1) begin
            failures++;
            $display("FAIL full_pop_write: level=%0d full=%b ovf=%b en=%b, required 16 1 0 1",
                     level, full, overflow, uart_tx_en);
        end
        wait_idle(600, "full_pop");
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_pop_ovf: ovf=%b, required 0", overflow);
        end
    endtask

    task automatic test_wrap();
        int sizes [8] = '{3, 7, 1, 5, 9, 2, 6, 7};
        logic [7:0] k = 8'h50;
        busy_len = 3;
        foreach (sizes[b]) begin
            bit room = 1'b0;
            for (int i = 0; i < 400; i++) begin
                @(negedge cpu_clk);
                if (int'(level) + sizes[b] <= DEPTH) begin
                    room = 1'b1;
                    break;
                end
            end
            checks++;
            if (!room) begin
                failures++;
                $display("FAIL wrap_room: level=%0d stuck, required drain", level);
            end
            for (int i = 0; i < int'($urandom_range(0, 4)); i++) @(negedge cpu_clk);
            @(posedge cpu_clk);
            #1;
            for (int i = 0; i < sizes[b]; i++) begin
                write_byte(k, 1'b1);
                k = k + 8'd1;
            end
        end
        wait_idle(1000, "wrap");
        checks++;
        if (level !== 0 || empty !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL wrap_end: level=%0d empty=%b ovf=%b, required 0 1 0",
                     level, empty, overflow);
        end
    endtask

    task automatic test_reset_mid();
        int start;
        busy_len = 20;
        @(posedge cpu_clk);
        #1;
        for (int i = 0; i < 4; i++) write_byte(8'hE0 + 8'(i), 1'b1);
        @(posedge cpu_clk);
        #1;
        rstn = 1'b0;
        @(posedge cpu_clk);
        @(posedge cpu_clk);
        #1;
        exp_q.delete();
        rstn = 1'b1;
        start = en_count;
        @(negedge cpu_clk);
        checks++;
        if (level !== 0 || empty !== 1'b1 || idle !== 1'b1 || uart_tx_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: level=%0d empty=%b idle=%b en=%b, required 0 1 1 0",
                     level, empty, idle, uart_tx_en);
        end
        for (int i = 0; i < 10; i++) @(negedge cpu_clk);
        checks++;
        if (en_count != start) begin
            failures++;
            $display("FAIL reset_mid_flush: %0d en pulses after reset, required 0",
                     en_count - start);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_overflow();
        test_write_pop_full();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer between the CPU memory-mapped UART data write strobe and the uart_tx serialiser.
- Accepts byte writes in single cycles and queues them in a circular FIFO. Drains the FIFO into uart_tx one byte at a time via its en/busy handshake, so firmware need not poll uart_tx_busy before every byte.
- Provides level, full, empty and a sticky overflow flag for the UART status register.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16 bytes); legal range 1..8.

Ports:
- cpu_clk  input  1  system clock; all logic on posedge.
- rstn  input  1  synchronous active-low reset.
- wr_en  input  1  one-cycle write strobe from the bus decode (data write to the UART data address).
- wr_data  input  8  byte to enqueue; sampled when wr_en=1.
- clr_overflow  input  1  one-cycle pulse; clears the overflow flag.
- uart_tx_busy  input  1  busy from uart_tx.
- uart_tx_en  output  1  one-cycle start pulse to uart_tx.
- uart_tx_data  output  8  byte presented to uart_tx; valid while uart_tx_en=1.
- level  output  DEPTH_LOG2+1  bytes currently stored.
- empty  output  1  level==0.
- full  output  1  level==2^DEPTH_LOG2.
- overflow  output  1  sticky: a write was dropped because the FIFO was full.
- idle  output  1  FIFO empty and FSM in IDLE, i.e. all bytes handed off and uart_tx not busy.

Behaviour:
- Reset (rstn=0 at posedge), all outputs and state:
  - wr_ptr=rd_ptr=0, level=0, empty=1, full=0, overflow=0.
  - uart_tx_en=0, uart_tx_data=0, FSM=IDLE, idle=1.
  - Storage contents are don't-care.
- Reset mid-transmission discards all queued bytes. A byte already handed to uart_tx is uart_tx's concern; uart_tx is reset by the same rstn.
- Storage:
  - Array of 2^DEPTH_LOG2 x 8 bits with pointers of DEPTH_LOG2 bits.
  - Pointers wrap modulo depth. level is a separate counter; it is not derived from the pointers.
- Write:
  - When wr_en=1 and (full=0 or pop occurs the same cycle), wr_data is stored at wr_ptr and wr_ptr increments.
  - When wr_en=1, full=1 and no pop occurs, the byte is dropped and overflow is set. level is unchanged.
- Pop:
  - Occurs in the cycle the FSM leaves IDLE with empty=0.
  - uart_tx_data is registered from mem[rd_ptr] and rd_ptr increments.
- level update:
  - write only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
  - empty and full are combinational from level.
- Write into an empty FIFO: the byte becomes poppable the following cycle. There is no same-cycle bypass. Minimum latency from wr_en to uart_tx_en is 2 cycles.
- FSM (state changes on posedge):
  - IDLE: if empty=0 and uart_tx_busy=0, pop and go to LAUNCH. Otherwise stay.
  - LAUNCH: uart_tx_en=1 for exactly this cycle, with uart_tx_data stable. Go to GUARD.
  - GUARD: one cycle, busy ignored; uart_tx raises busy the cycle after it samples en. Go to DRAIN.
  - DRAIN: stay while uart_tx_busy=1. When it is 0, go to IDLE.
- Back-to-back bytes: the next LAUNCH occurs no earlier than 2 cycles after busy falls (DRAIN->IDLE->LAUNCH).
- uart_tx_en is never asserted outside LAUNCH. uart_tx_data holds its value until the next pop.
- overflow:
  - set has priority over clr_overflow in the same cycle.
  - Otherwise clr_overflow clears it.
- idle = empty & (FSM==IDLE) & ~uart_tx_busy.
- Target size 150-250 lines RTL. No combinational path from uart_tx_busy to uart_tx_en.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with wr_en toggling -> level=0, empty=1, full=0, overflow=0, uart_tx_en=0, idle=1 after release.
- Single byte: wr_en with 8'h41 at cycle N, busy model asserts 1 cycle after en for 128 cycles -> uart_tx_en high only at N+2 with data 8'h41; level returns 0 at N+2; idle=1 two cycles after busy falls.
- Burst order: write 8'h01..8'h05 on consecutive cycles -> uart_tx_data sequence 01,02,03,04,05; exactly one en pulse per byte; each en occurs ≥2 cycles after busy deasserts.
- Full and overflow: with busy held high, write 17 bytes (DEPTH_LOG2=4) -> full=1 after 16 bytes (after the first pop, 17 bytes fit); a further write sets overflow=1 and level stays 16; clr_overflow clears it; a same-cycle drop plus clr leaves overflow=1.
- Simultaneous write and pop at full: hold a full FIFO, release busy, write 8'hAA in the pop cycle -> write accepted, level stays 16, overflow stays 0, 8'hAA emerges last.
- Wrap-around: push and drain 40 bytes in mixed bursts -> pointers wrap twice; output order is identical to input order; level never exceeds 16 or underflows.
